// File: rtl/pcd_to_picc_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pcd_to_picc_decoder
// Brief    : ISO 14443A reader-to-card modified-Miller decoder. Samples the
//            synchronised carrier envelope once per quarter bit period,
//            classifies each bit period as X/Y/Z, and assembles up to
//            MAX_BYTES odd-parity protected bytes per frame.
// Revision : 1.0 - initial release
// ============================================================================
module pcd_to_picc_decoder #(
  parameter int MAX_BYTES   = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               env_in,
  output logic                               rx_busy,
  output logic [8*MAX_BYTES-1:0]             rx_data,
  output logic [$clog2(MAX_BYTES+1)-1:0]     rx_num_bytes,
  output logic                               rx_valid,
  output logic                               rx_parity_err,
  output logic                               rx_code_err
);

  localparam int c_cnt_w  = $clog2(MAX_BYTES + 1);
  localparam int c_data_w = 8 * MAX_BYTES;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_sof  = 2'd1;
  localparam logic [1:0] c_st_bits = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  // Quarter-sample patterns, bit n = "carrier low in quarter n".
  localparam logic [3:0] c_pat_z = 4'b0001;
  localparam logic [3:0] c_pat_x = 4'b0100;
  localparam logic [3:0] c_pat_y = 4'b0000;

  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [SYNC_STAGES:0]    sync_ext;
  logic                    s;

  logic [1:0]              state_q, state_d;
  logic [1:0]              q_q, q_d;
  logic [2:0]              lo_q, lo_d;
  logic                    prev_q, prev_d;
  logic [3:0]              p_q, p_d;
  logic [c_cnt_w-1:0]      byte_q, byte_d;
  logic                    acc_q, acc_d;
  logic                    perr_q, perr_d;
  logic [c_data_w-1:0]     buf_q, buf_d;

  logic                    rx_busy_q, rx_busy_d;
  logic                    rx_valid_q, rx_valid_d;
  logic [c_data_w-1:0]     rx_data_q, rx_data_d;
  logic [c_cnt_w-1:0]      rx_num_bytes_q, rx_num_bytes_d;
  logic                    rx_parity_err_q, rx_parity_err_d;
  logic                    rx_code_err_q, rx_code_err_d;

  logic [c_data_w-1:0]     data_mask;
  logic [3:0]              pat;
  logic                    term, cerr, have_bit, bit_v;
  int                      wr_idx;

  // Shift chain: new envelope sample enters at bit 0, s is the oldest stage.
  assign sync_ext = {sync_q, env_in};
  assign sync_d   = sync_ext[SYNC_STAGES-1:0];
  assign s        = sync_q[SYNC_STAGES-1];

  // Only complete bytes are exposed on rx_data.
  for (genvar i = 0; i < MAX_BYTES; i++) begin : g_mask
    assign data_mask[8*i +: 8] = (int'(byte_q) > i) ? 8'hFF : 8'h00;
  end

  // Frame state machine: SOF check, bit classification, byte assembly.
  always_comb begin
    state_d         = state_q;
    q_d             = q_q;
    lo_d            = lo_q;
    prev_d          = prev_q;
    p_d             = p_q;
    byte_d          = byte_q;
    acc_d           = acc_q;
    perr_d          = perr_q;
    buf_d           = buf_q;
    rx_busy_d       = rx_busy_q;
    rx_valid_d      = 1'b0;
    rx_data_d       = rx_data_q;
    rx_num_bytes_d  = rx_num_bytes_q;
    rx_parity_err_d = rx_parity_err_q;
    rx_code_err_d   = rx_code_err_q;
    pat             = {~s, lo_q};
    term            = 1'b0;
    cerr            = 1'b0;
    have_bit        = 1'b0;
    bit_v           = 1'b0;
    wr_idx          = 8 * int'(byte_q) + int'(p_q);

    case (state_q)
      c_st_idle: begin
        if (!s) begin
          buf_d     = '0;
          p_d       = 4'd0;
          byte_d    = '0;
          acc_d     = 1'b0;
          perr_d    = 1'b0;
          q_d       = 2'd1;
          lo_d      = 3'b000;
          prev_d    = 1'b0;
          rx_busy_d = 1'b1;
          state_d   = c_st_sof;
        end
      end

      c_st_sof: begin
        if (!s) begin
          term = 1'b1;
          cerr = 1'b1;
        end else if (q_q == 2'd3) begin
          q_d     = 2'd0;
          lo_d    = 3'b000;
          state_d = c_st_bits;
        end else begin
          q_d = q_q + 2'd1;
        end
      end

      c_st_bits: begin
        if (q_q != 2'd3) begin
          case (q_q)
            2'd0:    lo_d[0] = ~s;
            2'd1:    lo_d[1] = ~s;
            default: lo_d[2] = ~s;
          endcase
          q_d = q_q + 2'd1;
        end else begin
          q_d  = 2'd0;
          lo_d = 3'b000;
          if (pat == c_pat_x) begin
            have_bit = 1'b1;
            bit_v    = 1'b1;
            prev_d   = 1'b1;
          end else if (pat == c_pat_z) begin
            // A pause in q0 cannot follow a logic 1 in modified Miller.
            if (prev_q) begin
              term = 1'b1;
              cerr = 1'b1;
            end else begin
              have_bit = 1'b1;
            end
          end else if (pat == c_pat_y) begin
            if (prev_q) begin
              have_bit = 1'b1;
              prev_d   = 1'b0;
            end else begin
              // EOF: the preceding 0 was the EOF logic-0 and had to start a
              // new group, so p has advanced exactly once past it.
              term = 1'b1;
              cerr = !((p_q == 4'd1) && (byte_q != '0));
            end
          end else begin
            term = 1'b1;
            cerr = 1'b1;
          end

          if (have_bit) begin
            if ((p_q != 4'd0) && (byte_q == c_cnt_w'(MAX_BYTES))) begin
              term = 1'b1;
              cerr = 1'b1;
            end else if (p_q == 4'd8) begin
              if (bit_v != ~acc_q) begin
                perr_d = 1'b1;
              end
              byte_d = byte_q + c_cnt_w'(1);
              acc_d  = 1'b0;
              p_d    = 4'd0;
            end else begin
              for (int i = 0; i < c_data_w; i++) begin
                if (i == wr_idx) begin
                  buf_d[i] = bit_v;
                end
              end
              acc_d = acc_q ^ bit_v;
              p_d   = p_q + 4'd1;
            end
          end
        end
      end

      default: begin
        state_d = c_st_idle;
      end
    endcase

    if (term) begin
      state_d         = c_st_done;
      rx_valid_d      = 1'b1;
      rx_busy_d       = 1'b0;
      rx_data_d       = buf_q & data_mask;
      rx_num_bytes_d  = byte_q;
      rx_parity_err_d = perr_q;
      rx_code_err_d   = cerr;
    end
  end

  // State and output registers; the synchroniser resets to "carrier on" so
  // reset release never looks like a pause.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q          <= '1;
      state_q         <= c_st_idle;
      q_q             <= 2'd0;
      lo_q            <= 3'b000;
      prev_q          <= 1'b0;
      p_q             <= 4'd0;
      byte_q          <= '0;
      acc_q           <= 1'b0;
      perr_q          <= 1'b0;
      buf_q           <= '0;
      rx_busy_q       <= 1'b0;
      rx_valid_q      <= 1'b0;
      rx_data_q       <= '0;
      rx_num_bytes_q  <= '0;
      rx_parity_err_q <= 1'b0;
      rx_code_err_q   <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      state_q         <= state_d;
      q_q             <= q_d;
      lo_q            <= lo_d;
      prev_q          <= prev_d;
      p_q             <= p_d;
      byte_q          <= byte_d;
      acc_q           <= acc_d;
      perr_q          <= perr_d;
      buf_q           <= buf_d;
      rx_busy_q       <= rx_busy_d;
      rx_valid_q      <= rx_valid_d;
      rx_data_q       <= rx_data_d;
      rx_num_bytes_q  <= rx_num_bytes_d;
      rx_parity_err_q <= rx_parity_err_d;
      rx_code_err_q   <= rx_code_err_d;
    end
  end

  assign rx_busy       = rx_busy_q;
  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_num_bytes  = rx_num_bytes_q;
  assign rx_parity_err = rx_parity_err_q;
  assign rx_code_err   = rx_code_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pcd_to_picc_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcd_to_picc_decoder
// Brief    : Self-checking bench. Frames are built as modified-Miller symbol
//            lists, expected results are queued as each frame is played and
//            compared when rx_valid fires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcd_to_picc_decoder;

  localparam int SYM_Z = 0;
  localparam int SYM_X = 1;
  localparam int SYM_Y = 2;
  localparam int SYM_P = 3;   // illegal: pause across q0 and q1

  typedef struct {
    logic [39:0] data;
    int          num;
    logic        perr;
    logic        cerr;
    int          cyc;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        env_in = 1'b1;
  logic        rx_busy;
  logic [39:0] rx_data;
  logic [2:0]  rx_num_bytes;
  logic        rx_valid;
  logic        rx_parity_err;
  logic        rx_code_err;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   sym_q[$];
  exp_t sb[$];
  logic enc_prev;
  logic prev_v = 1'b0;

  pcd_to_picc_decoder #(.MAX_BYTES(5), .SYNC_STAGES(2)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .env_in        (env_in),
    .rx_busy       (rx_busy),
    .rx_data       (rx_data),
    .rx_num_bytes  (rx_num_bytes),
    .rx_valid      (rx_valid),
    .rx_parity_err (rx_parity_err),
    .rx_code_err   (rx_code_err)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: pop and compare on every rx_valid pulse.
  always @(negedge clk_in) begin
    if (prev_v) chk("valid_pulse", {63'd0, rx_valid}, 64'd0);
    prev_v <= rx_valid;
    if (rx_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rx_data",       {24'd0, rx_data},          {24'd0, e.data});
        chk("rx_num_bytes",  {61'd0, rx_num_bytes},     64'(e.num));
        chk("rx_parity_err", {63'd0, rx_parity_err},    {63'd0, e.perr});
        chk("rx_code_err",   {63'd0, rx_code_err},      {63'd0, e.cerr});
        chk("rx_busy_fall",  {63'd0, rx_busy},          64'd0);
        chk("valid_cycle",   64'(cyc),                  64'(e.cyc));
      end
    end
  end

  // Modified-Miller encoder model.
  task automatic start_frame();
    sym_q.delete();
    sym_q.push_back(SYM_Z);
    enc_prev = 1'b0;
  endtask

  task automatic add_bit(input logic b);
    if (b) begin
      sym_q.push_back(SYM_X);
      enc_prev = 1'b1;
    end else begin
      sym_q.push_back(enc_prev ? SYM_Y : SYM_Z);
      enc_prev = 1'b0;
    end
  endtask

  task automatic add_byte(input logic [7:0] b, input logic bad_par);
    logic par;
    for (int i = 0; i < 8; i++) add_bit(b[i]);
    par = ~^b;
    add_bit(bad_par ? ~par : par);
  endtask

  task automatic add_eof();
    add_bit(1'b0);
    sym_q.push_back(SYM_Y);
  endtask

  // Drive the symbol list one quarter per clock. abort_at >= 0 asserts reset
  // at the start of that symbol instead of finishing the frame.
  task automatic play(input int abort_at, output int last);
    logic [3:0] pat;
    last = 0;
    for (int i = 0; i < sym_q.size(); i++) begin
      if (i == abort_at) begin
        chk("busy_mid_frame", {63'd0, rx_busy}, 64'd1);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        env_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_busy",  {63'd0, rx_busy},      64'd0);
        chk("rst_data",  {24'd0, rx_data},      64'd0);
        chk("rst_num",   {61'd0, rx_num_bytes}, 64'd0);
        chk("rst_valid", {63'd0, rx_valid},     64'd0);
        chk("rst_cerr",  {63'd0, rx_code_err},  64'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        return;
      end
      case (sym_q[i])
        SYM_Z:   pat = 4'b1110;
        SYM_X:   pat = 4'b1011;
        SYM_Y:   pat = 4'b1111;
        default: pat = 4'b1100;
      endcase
      for (int qq = 0; qq < 4; qq++) begin
        @(posedge clk_in); #1;
        env_in = pat[qq];
        last   = cyc;
      end
    end
    @(posedge clk_in); #1;
    env_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
      env_in = 1'b1;
    end
  endtask

  task automatic run_frame(input logic [39:0] d, input int num, input logic perr, input logic cerr);
    exp_t e;
    int   last;
    play(-1, last);
    e.data = d;
    e.num  = num;
    e.perr = perr;
    e.cerr = cerr;
    e.cyc  = last + 3;
    sb.push_back(e);
    for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge clk_in);
    if (sb.size() != 0) begin
      chk("frame_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    idle(6);
  endtask

  initial begin
    int last;
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    chk("reset_busy",  {63'd0, rx_busy},       64'd0);
    chk("reset_valid", {63'd0, rx_valid},      64'd0);
    chk("reset_data",  {24'd0, rx_data},       64'd0);
    chk("reset_num",   {61'd0, rx_num_bytes},  64'd0);
    chk("reset_perr",  {63'd0, rx_parity_err}, 64'd0);
    chk("reset_cerr",  {63'd0, rx_code_err},   64'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    idle(6);

    // Clean 0x93 frame.
    start_frame(); add_byte(8'h93, 1'b0); add_eof();
    run_frame(40'h93, 1, 1'b0, 1'b0);

    // 0x93 with wrong parity.
    start_frame(); add_byte(8'h93, 1'b1); add_eof();
    run_frame(40'h93, 1, 1'b1, 1'b0);

    // Five bytes, full buffer.
    start_frame();
    add_byte(8'h01, 1'b0); add_byte(8'h02, 1'b0); add_byte(8'h04, 1'b0);
    add_byte(8'h08, 1'b0); add_byte(8'hFF, 1'b0); add_eof();
    run_frame(40'hFF08040201, 5, 1'b0, 1'b0);

    // Overflow: second bit of a sixth byte.
    start_frame();
    add_byte(8'h01, 1'b0); add_byte(8'h02, 1'b0); add_byte(8'h04, 1'b0);
    add_byte(8'h08, 1'b0); add_byte(8'hFF, 1'b0);
    add_bit(1'b1); add_bit(1'b1);
    run_frame(40'hFF08040201, 5, 1'b0, 1'b1);

    // Pause spanning q0 and q1.
    start_frame(); add_bit(1'b1); sym_q.push_back(SYM_P);
    run_frame(40'h0, 0, 1'b0, 1'b1);

    // Z directly after X.
    start_frame(); add_bit(1'b1); sym_q.push_back(SYM_Z);
    run_frame(40'h0, 0, 1'b0, 1'b1);

    // SOF immediately followed by Y: empty frame.
    start_frame(); sym_q.push_back(SYM_Y);
    run_frame(40'h0, 0, 1'b0, 1'b1);

    // EOF after 4 data bits.
    start_frame();
    add_bit(1'b1); add_bit(1'b1); add_bit(1'b0); add_bit(1'b0); add_eof();
    run_frame(40'h0, 0, 1'b0, 1'b1);

    // Frame with one good byte then a parity error, checks sticky flag.
    start_frame(); add_byte(8'hA5, 1'b0); add_byte(8'h3C, 1'b1); add_eof();
    run_frame(40'h3CA5, 2, 1'b1, 1'b0);

    // Reset during the third byte, then a clean frame.
    start_frame();
    add_byte(8'h11, 1'b0); add_byte(8'h22, 1'b0); add_byte(8'h33, 1'b0); add_eof();
    play(22, last);
    idle(10);
    start_frame(); add_byte(8'h93, 1'b0); add_eof();
    run_frame(40'h93, 1, 1'b0, 1'b0);

    idle(10);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
